// File: rtl/mult_control.sv
// Control FSM for the 8-bit shift-add signed multiplier.
// Sequences load/clear, N add-then-shift iterations (the last one subtracts
// for the sign bit of the multiplier) and a completion handshake on Run.
module mult_control #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Run,
    input  logic          ClearA_LoadB,
    input  logic          M,
    output logic          Clr_XA,
    output logic          Ld_XA,
    output logic          Sub,
    output logic          Shift_En,
    output logic          Ld_B,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] Count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Count value seen during the final (sign-bit) iteration
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t state;
    state_t state_next;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Iteration counter: cleared on entry to the multiply, bumped per shift
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Count <= '0;
        end else if (state == CLR) begin
            Count <= '0;
        end else if (state == SHIFT) begin
            Count <= Count + CW'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = Run ? CLR : IDLE;
            CLR:     state_next = ADD;
            ADD:     state_next = SHIFT;
            SHIFT:   state_next = (Count == LAST) ? DONE : ADD;
            DONE:    state_next = Run ? DONE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; Ld_XA/Sub also follow M. Reset forces everything low
    // without waiting for a clock edge, even if IDLE would assert Ld_B.
    always_comb begin
        Clr_XA   = 1'b0;
        Ld_XA    = 1'b0;
        Sub      = 1'b0;
        Shift_En = 1'b0;
        Ld_B     = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            IDLE: begin
                if (!Run && ClearA_LoadB) begin
                    Ld_B   = 1'b1;
                    Clr_XA = 1'b1;
                end
            end
            CLR: begin
                Clr_XA = 1'b1;
                Busy   = 1'b1;
            end
            ADD: begin
                Busy  = 1'b1;
                Ld_XA = M;
                Sub   = M && (Count == LAST);
            end
            SHIFT: begin
                Busy     = 1'b1;
                Shift_En = 1'b1;
            end
            DONE: begin
                Done = 1'b1;
            end
            default: begin
            end
        endcase
        if (Reset) begin
            Clr_XA   = 1'b0;
            Ld_XA    = 1'b0;
            Sub      = 1'b0;
            Shift_En = 1'b0;
            Ld_B     = 1'b0;
            Busy     = 1'b0;
            Done     = 1'b0;
        end
    end

endmodule

// File: doc/mult_control.md
Name: mult_control

Overview:
Control FSM for the 8-bit shift-add signed multiplier built around the A/B shift-register pair.
- Loads B (multiplier) from switches and clears X/A.
- Sequences N add/subtract-then-shift iterations.
- Flags completion.
- Drives load/shift/clear strobes of the register unit and the add/sub select of the 9-bit adder; samples B's LSB (M) each iteration.

Parameters:
N, 8, number of multiplier bits / iterations (N >= 2)
CW, 4, iteration counter width; must satisfy 2^CW > N

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Run  input  1  start request, level, already synchronised/debounced
ClearA_LoadB  input  1  level; in IDLE: load B from switches, clear X/A
M  input  1  current multiplier LSB (B[0]), combinational from register unit
Clr_XA  output  1  synchronous clear of X flip-flop and A register
Ld_XA  output  1  load adder result into X and A
Sub  output  1  adder mode: 0 = A+S, 1 = A-S (two's complement)
Shift_En  output  1  arithmetic right shift of X:A:B by one
Ld_B  output  1  load B from switch bus
Busy  output  1  high from CLR through the final SHIFT
Done  output  1  high while in DONE
Count  output  CW  completed shift count, debug/verification visibility

Behaviour:
- Single clock; reset is asynchronous and active-high.
- Reset asserted, at any time including mid-multiply:
  - state = IDLE, Count = 0.
  - All outputs 0 immediately, without waiting for a Clk edge.
- States: IDLE, CLR, ADD, SHIFT, DONE. Moore outputs are decoded from the state register, except Ld_XA/Sub, which also depend on M (Mealy).
- IDLE:
  - Run=1: go to CLR next edge.
  - Run=0 and ClearA_LoadB=1: Ld_B=1 and Clr_XA=1 this cycle; stay in IDLE. Asserted every cycle the input is held.
  - Run and ClearA_LoadB both high: Run wins; no Ld_B.
- CLR: Clr_XA=1, Busy=1, Count <= 0; go to ADD.
- ADD: Busy=1.
  - Ld_XA = M.
  - Sub = M and (Count == N-1), i.e. the sign-bit iteration subtracts. Otherwise Sub = 0.
  - Go to SHIFT.
- SHIFT: Shift_En=1, Busy=1, Count <= Count+1.
  - If Count == N-1 (this is the Nth shift), go to DONE; else go to ADD.
- DONE: Done=1, all strobes 0.
  - Stay while Run=1 (no retrigger on a held Run).
  - Run=0: go to IDLE next edge.
  - ClearA_LoadB is ignored in DONE; it acts only after returning to IDLE.
- ClearA_LoadB is ignored in CLR/ADD/SHIFT.
- Run deassertion mid-multiply has no effect; the multiply always runs to completion.
- Latency:
  - Run sampled high in IDLE at edge 0.
  - CLR during cycle 1; ADD/SHIFT pairs occupy cycles 2..2N+1.
  - Done first high in cycle 2N+2 (cycle 18 for N=8).
- Exactly N Shift_En pulses and N ADD cycles per run; Shift_En and Ld_XA are never high in the same cycle.
- Count never exceeds N; it holds N in DONE and is cleared only in CLR or by reset.
- Outputs are glitch-free relative to state; M must be stable by mid-cycle in ADD.

Test Plan:
- Reset, then ClearA_LoadB=1 for 3 cycles, Run=0 -> Ld_B=1 and Clr_XA=1 in each of those 3 cycles; Busy=Done=0; state stays IDLE.
- M tied 1 (B=0xFF), pulse Run -> Clr_XA in cycle 1; Ld_XA=1 in cycles 2,4,...,16; Sub=1 only in cycle 16; Shift_En in cycles 3,5,...,17; Done=1 from cycle 18; Count=8.
- M tied 0 -> Ld_XA and Sub never asserted; 8 Shift_En pulses; Done in cycle 18.
- Run held high through completion -> Done stays 1 for 20 extra cycles with no new CLR. Run low -> IDLE next edge. Run high again -> new CLR, Count resets to 0.
- Reset asserted mid-run at Count=3 (in an ADD cycle) -> all outputs 0 before the next Clk edge; Count=0; after release, IDLE with Done=0.
- Run=1 and ClearA_LoadB=1 in the same IDLE cycle -> Ld_B=0, CLR entered next edge. ClearA_LoadB pulsed during SHIFT -> no Ld_B/Clr_XA.
